// File: rtl/reg_writeback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl_pkg
// Shared constants and types for the register-file write-back controller.
//   REG_ADDR_W : register index width (32 architectural registers)
//   XLEN       : register data width
//   REG_ZERO   : index of the hard-wired zero register (never written)
//   wb_entry_t : one pending write {valid, rd, data}
// ---------------------------------------------------------------------------
package reg_writeback_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl_if
// Bundles every non-clock/reset signal of the write-back controller.
//   ALU path      : alu_valid, alu_rd, alu_data (no backpressure)
//   mul/div path  : md_valid, md_ready, md_rd, md_data (valid/ready)
//   register file : wb_data, wb_addr, wb_en (registered write port)
//   hazard query  : pend_query -> pend_hit, plus pend_count
// Modports:
//   master : the pipeline / register-file side (drives results and queries)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface reg_writeback_ctrl_if import reg_writeback_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DEPTH      = 2
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  md_valid;
  logic                  md_ready;
  logic [ADDR_WIDTH-1:0] md_rd;
  logic [DATA_WIDTH-1:0] md_data;

  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  wb_en;

  logic [ADDR_WIDTH-1:0] pend_query;
  logic                  pend_hit;
  logic [CNT_W-1:0]      pend_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output pend_query,
    input  md_ready,
    input  wb_data, wb_addr, wb_en,
    input  pend_hit, pend_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  pend_query,
    output md_ready,
    output wb_data, wb_addr, wb_en,
    output pend_hit, pend_count
  );

endinterface

// File: rtl/reg_writeback_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// Small FIFO of pending mul/div write-backs with per-entry invalidation.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_rd/data  : enqueue one result at the tail
//   pop                 : consume the oldest live entry (head_*)
//   squash_en/rd        : invalidate every live entry targeting squash_rd
//   query_rd/query_hit  : hazard lookup of a destination register
//   full                : all slots occupied (live or squashed)
//   head_valid/rd/data  : oldest live entry
//   live_count          : number of live entries
// Squashed entries keep their slot until the read pointer sweeps past them;
// the sweep happens in the same edge, so they never cost a drain cycle.
// ---------------------------------------------------------------------------
module wb_result_fifo import reg_writeback_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [ADDR_WIDTH-1:0] squash_rd,
  input  logic [ADDR_WIDTH-1:0] query_rd,
  output logic                  full,
  output logic                  head_valid,
  output logic [ADDR_WIDTH-1:0] head_rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      live_count,
  output logic                  query_hit
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]        rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]        occupancy;
  logic [DEPTH-1:0]      valid_reg, valid_next;
  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [DEPTH-1:0]      squash_hit;
  logic [DEPTH-1:0]      valid_eff;
  logic [DEPTH-1:0]      hit_vec;

  logic                  head_found;
  logic [PTR_W-1:0]      head_idx;
  logic [PTR_W:0]        head_off;
  logic                  pop_fire;
  logic                  push_keep;
  logic [PTR_W-1:0]      wr_idx;

  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == CNT_W'(DEPTH));
  assign wr_idx    = wr_ptr_reg[PTR_W-1:0];

  // A result arriving in the same cycle as an ALU write to the same rd is
  // older than that ALU write, so it is dropped rather than enqueued.
  assign push_keep = push && !(squash_en && (push_rd == squash_rd));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign squash_hit[gi] = squash_en && valid_reg[gi] && (rd_mem[gi] == squash_rd);
      assign valid_eff[gi]  = valid_reg[gi] && !squash_hit[gi];
      // The entry leaving this cycle no longer blocks readers.
      assign hit_vec[gi]    = valid_eff[gi] && (rd_mem[gi] == query_rd) &&
                              !(pop_fire && (head_idx == PTR_W'(gi)));
    end
  endgenerate

  assign query_hit = |hit_vec;

  // Oldest live entry, scanning forward from the read pointer.  Valid bits
  // only ever exist inside the occupied window, so no occupancy test is needed.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    head_found = 1'b0;
    head_idx   = rd_ptr_reg[PTR_W-1:0];
    head_off   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg[PTR_W-1:0] + PTR_W'(k);
      if (!head_found && valid_eff[idx]) begin
        head_found = 1'b1;
        head_idx   = idx;
        head_off   = CNT_W'(k);
      end
    end
  end

  assign head_valid = head_found;
  assign head_rd    = rd_mem[head_idx];
  assign head_data  = data_mem[head_idx];
  assign pop_fire   = pop && head_found;

  // Skip leading dead slots; with no live entry, release the whole window.
  always_comb begin
    if (head_found) begin
      rd_ptr_next = rd_ptr_reg + head_off + CNT_W'(pop_fire);
    end else begin
      rd_ptr_next = wr_ptr_reg;
    end
    wr_ptr_next = wr_ptr_reg + CNT_W'(push_keep);
  end

  always_comb begin
    valid_next = valid_eff;
    if (pop_fire) begin
      valid_next[head_idx] = 1'b0;
    end
    if (push_keep) begin
      valid_next[wr_idx] = 1'b1;
    end
  end

  always_comb begin
    live_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live_count = live_count + CNT_W'(valid_reg[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= valid_next;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (push_keep) begin
      rd_mem[wr_idx]   <= push_rd;
      data_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl
// Write-side controller for the 32x32 register file.  Merges the non-stalling
// ALU/load result and the buffered mul/div result into one registered write
// per cycle, ALU first, and reports pending mul/div destinations.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; discards all queued results
//   bus  : reg_writeback_ctrl_if.slave (ALU, mul/div, write port, hazard query)
// Build option:
//   WB_BYPASS_EN : when defined, a mul/div result accepted while the FIFO has
//                  no live entry and no ALU result is present is written
//                  directly (1-cycle latency) instead of being enqueued.
// ---------------------------------------------------------------------------
module reg_writeback_ctrl import reg_writeback_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_write;
  logic                  md_accept;
  logic                  md_nonzero;
  logic                  bypass_take;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  head_valid;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CNT_W-1:0]      live_count;
  logic                  pend_hit;

  logic                  wb_en_reg,   wb_en_next;
  logic [ADDR_WIDTH-1:0] wb_addr_reg, wb_addr_next;
  logic [DATA_WIDTH-1:0] wb_data_reg, wb_data_next;

  assign alu_write  = bus.alu_valid && (bus.alu_rd != ADDR_WIDTH'(REG_ZERO));
  // Ready comes from the registered full flag only, so a drain in this cycle
  // cannot open a combinational path from the pop back to the producer.
  assign md_accept  = bus.md_valid && !fifo_full;
  assign md_nonzero = (bus.md_rd != ADDR_WIDTH'(REG_ZERO));

`ifdef WB_BYPASS_EN
  assign bypass_take = md_accept && md_nonzero && !bus.alu_valid && (live_count == '0);
`else
  assign bypass_take = 1'b0;
`endif

  // x0 results complete the handshake but are dropped here.
  assign fifo_push = md_accept && md_nonzero && !bypass_take;
  assign fifo_pop  = head_valid && !alu_write;

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_rd    (bus.md_rd),
    .push_data  (bus.md_data),
    .pop        (fifo_pop),
    .squash_en  (alu_write),
    .squash_rd  (bus.alu_rd),
    .query_rd   (bus.pend_query),
    .full       (fifo_full),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .live_count (live_count),
    .query_hit  (pend_hit)
  );

  // Write selection: ALU, then oldest live queued result, then bypass.
  // When nothing is written, address and data keep their last values.
  always_comb begin
    wb_en_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    if (alu_write) begin
      wb_en_next   = 1'b1;
      wb_addr_next = bus.alu_rd;
      wb_data_next = bus.alu_data;
    end else if (head_valid) begin
      wb_en_next   = 1'b1;
      wb_addr_next = head_rd;
      wb_data_next = head_data;
    end else if (bypass_take) begin
      wb_en_next   = 1'b1;
      wb_addr_next = bus.md_rd;
      wb_data_next = bus.md_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg   <= wb_en_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
    end
  end

  assign bus.md_ready   = !fifo_full;
  assign bus.wb_en      = wb_en_reg;
  assign bus.wb_addr    = wb_addr_reg;
  assign bus.wb_data    = wb_data_reg;
  assign bus.pend_hit   = pend_hit;
  assign bus.pend_count = live_count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_ctrl
// Directed bench for reg_writeback_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus ();

  reg_writeback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic wb_entry_t mk(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_entry_t e;
    e.valid = v;
    e.rd    = rd;
    e.data  = d;
    return e;
  endfunction

  // Write-port check; address/data are compared only when a write is expected.
  task automatic check_wb(input string tag, input wb_entry_t exp);
    check({tag, ".wb_en"}, 32'(bus.wb_en), 32'(exp.valid));
    if (exp.valid) begin
      check({tag, ".wb_addr"}, 32'(bus.wb_addr), 32'(exp.rd));
      check({tag, ".wb_data"}, bus.wb_data, exp.data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.md_valid = v;
    bus.md_rd    = rd;
    bus.md_data  = d;
  endtask

  initial begin
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_md(1'b0, 5'd0, 32'h0);
    bus.pend_query = 5'd0;

    // Reset state
    tick();
    tick();
    check("rst.wb_en", 32'(bus.wb_en), 32'h0);
    check("rst.wb_addr", 32'(bus.wb_addr), 32'h0);
    check("rst.wb_data", bus.wb_data, 32'h0);
    check("rst.pend_count", 32'(bus.pend_count), 32'h0);
    check("rst.md_ready", 32'(bus.md_ready), 32'h1);
    rst = 1'b0;
    tick();

    // ALU only, then ALU to x0 (no write, address/data hold)
    drive_alu(1'b1, 5'd5, 32'h2);
    tick();
    check_wb("alu5", mk(1'b1, 5'd5, 32'h2));
    drive_alu(1'b1, 5'd0, 32'h33);
    tick();
    check("alu0.wb_en", 32'(bus.wb_en), 32'h0);
    check("alu0.hold_addr", 32'(bus.wb_addr), 32'd5);
    check("alu0.hold_data", bus.wb_data, 32'h2);

    // Mul/div to x0: accepted, never queued
    drive_alu(1'b1, 5'd10, 32'h10);
    drive_md(1'b1, 5'd0, 32'h77);
    #1;
    check("mdx0.md_ready", 32'(bus.md_ready), 32'h1);
    tick();
    check_wb("mdx0", mk(1'b1, 5'd10, 32'h10));
    check("mdx0.pend_count", 32'(bus.pend_count), 32'h0);
    drive_md(1'b0, 5'd0, 32'h0);

    // Contention: rd7 queued behind ALU writes to 1,2,3
    drive_alu(1'b1, 5'd1, 32'h101);
    drive_md(1'b1, 5'd7, 32'hAAAA0000);
    tick();
    check_wb("cont.w1", mk(1'b1, 5'd1, 32'h101));
    check("cont.pend_count", 32'(bus.pend_count), 32'h1);
    drive_md(1'b0, 5'd0, 32'h0);
    drive_alu(1'b1, 5'd2, 32'h202);
    bus.pend_query = 5'd7;
    #1;
    check("cont.pend_hit7", 32'(bus.pend_hit), 32'h1);
    tick();
    check_wb("cont.w2", mk(1'b1, 5'd2, 32'h202));
    drive_alu(1'b1, 5'd3, 32'h303);
    tick();
    check_wb("cont.w3", mk(1'b1, 5'd3, 32'h303));
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();
    check_wb("cont.w4", mk(1'b1, 5'd7, 32'hAAAA0000));
    check("cont.pend_count_end", 32'(bus.pend_count), 32'h0);
    tick();
    check("cont.idle.wb_en", 32'(bus.wb_en), 32'h0);

    // Backpressure: ALU busy, three mul/div offers into a 2-deep FIFO
    drive_alu(1'b1, 5'd10, 32'hA0);
    drive_md(1'b1, 5'd11, 32'hB1);
    #1;
    check("bp.ready0", 32'(bus.md_ready), 32'h1);
    tick();
    check_wb("bp.alu0", mk(1'b1, 5'd10, 32'hA0));
    check("bp.count1", 32'(bus.pend_count), 32'h1);
    drive_alu(1'b1, 5'd10, 32'hA1);
    drive_md(1'b1, 5'd12, 32'hB2);
    #1;
    check("bp.ready1", 32'(bus.md_ready), 32'h1);
    tick();
    check_wb("bp.alu1", mk(1'b1, 5'd10, 32'hA1));
    check("bp.count2", 32'(bus.pend_count), 32'h2);
    drive_alu(1'b1, 5'd10, 32'hA2);
    drive_md(1'b1, 5'd13, 32'hB3);
    #1;
    check("bp.ready_full", 32'(bus.md_ready), 32'h0);
    tick();
    check_wb("bp.alu2", mk(1'b1, 5'd10, 32'hA2));
    check("bp.count_held", 32'(bus.pend_count), 32'h2);
    drive_alu(1'b0, 5'd0, 32'h0);
    #1;
    check("bp.ready_during_pop", 32'(bus.md_ready), 32'h0);
    tick();
    check_wb("bp.drain11", mk(1'b1, 5'd11, 32'hB1));
    check("bp.count_after_pop", 32'(bus.pend_count), 32'h1);
    check("bp.ready_reopen", 32'(bus.md_ready), 32'h1);
    tick();
    check_wb("bp.drain12", mk(1'b1, 5'd12, 32'hB2));
    check("bp.count_push_pop", 32'(bus.pend_count), 32'h1);
    drive_md(1'b0, 5'd0, 32'h0);
    tick();
    check_wb("bp.drain13", mk(1'b1, 5'd13, 32'hB3));
    check("bp.count_empty", 32'(bus.pend_count), 32'h0);

    // Squash: queued rd9 overtaken by an ALU write to r9
    drive_alu(1'b1, 5'd0, 32'h0);
    drive_md(1'b1, 5'd9, 32'h11);
    tick();
    check("sq.push.wb_en", 32'(bus.wb_en), 32'h0);
    check("sq.count1", 32'(bus.pend_count), 32'h1);
    drive_md(1'b0, 5'd0, 32'h0);
    drive_alu(1'b1, 5'd20, 32'h33);
    bus.pend_query = 5'd9;
    #1;
    check("sq.hit_before", 32'(bus.pend_hit), 32'h1);
    drive_alu(1'b1, 5'd9, 32'h22);
    #1;
    check("sq.hit_squashing", 32'(bus.pend_hit), 32'h0);
    tick();
    check_wb("sq.alu9", mk(1'b1, 5'd9, 32'h22));
    check("sq.count0", 32'(bus.pend_count), 32'h0);
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();
    check("sq.no_stale.wb_en", 32'(bus.wb_en), 32'h0);

    // Mul/div latency into an empty FIFO
    drive_md(1'b1, 5'd4, 32'h55);
    tick();
    drive_md(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    check_wb("byp.w4", mk(1'b1, 5'd4, 32'h55));
    check("byp.count", 32'(bus.pend_count), 32'h0);
`else
    check("lat.cycle1.wb_en", 32'(bus.wb_en), 32'h0);
    check("lat.count", 32'(bus.pend_count), 32'h1);
    tick();
    check_wb("lat.w4", mk(1'b1, 5'd4, 32'h55));
`endif
    tick();
    check("lat.idle.wb_en", 32'(bus.wb_en), 32'h0);

    // Reset mid-stream with two entries queued
    drive_alu(1'b1, 5'd10, 32'hC0);
    drive_md(1'b1, 5'd14, 32'hC1);
    tick();
    drive_alu(1'b1, 5'd10, 32'hC3);
    drive_md(1'b1, 5'd15, 32'hC2);
    tick();
    check("mrst.count2", 32'(bus.pend_count), 32'h2);
    check("mrst.wb_en_before", 32'(bus.wb_en), 32'h1);
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_md(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    check("mrst.wb_en", 32'(bus.wb_en), 32'h0);
    check("mrst.pend_count", 32'(bus.pend_count), 32'h0);
    check("mrst.md_ready", 32'(bus.md_ready), 32'h1);
    check("mrst.wb_addr", 32'(bus.wb_addr), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mrst.discard%0d.wb_en", i), 32'(bus.wb_en), 32'h0);
    end
    check("mrst.count_after", 32'(bus.pend_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
